// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit sequencer and baud counter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 16;

  // Baud counter width; a counter of $clog2(N) bits spans 0..N-1
  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  // The shifter emits stage 7 first, so the LSB must land in p[7]
  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_seq_if.sv
// rtl/uart_tx_seq_if.sv - byte-side valid/ready handshake into the transmit sequencer
interface uart_tx_seq_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with enable, synchronous clear and period-end flag
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  localparam int CW           = baud_cnt_w(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(CLKS_PER_BIT - 1));

  // Count 0..CLKS_PER_BIT-1 while enabled, wrapping at the end of each bit period
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_seq.sv
// rtl/uart_tx_seq.sv - drives an external sn74ls166 shifter and frames its output as a UART line
module uart_tx_seq
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  uart_tx_seq_if.slave      tx,
  output logic              sh_ld_n,
  output logic              clk_inh,
  output logic              ser,
  output logic [7:0]        p,
  input  logic              q,
  output logic              txd
);

  localparam int   CW        = baud_cnt_w(CLKS_PER_BIT);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t        state, state_nxt;
  logic          ready_q, ready_nxt;
  logic          busy_q, busy_nxt;
  logic          ld_nxt, inh_nxt, txd_nxt;
  logic [7:0]    p_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic          stop_cnt, stop_nxt;

  logic [CW-1:0] baud_cnt;
  logic          baud_last;
  logic          baud_en;
  logic          baud_clr;
  logic          pre_last;

  assign tx.tx_ready = ready_q;
  assign tx.tx_busy  = busy_q;

  assign baud_en  = (state == START) || (state == DATA) || (state == STOP);
  assign baud_clr = (state == IDLE) || (state == LOAD);
  // The shift pulse is registered one cycle early so it lands in the last cycle of the period
  assign pre_last = (baud_cnt == CW'(CLKS_PER_BIT - 2));

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (baud_en),
    .clr  (baud_clr),
    .cnt  (baud_cnt),
    .last (baud_last)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      sh_ld_n  <= 1'b1;
      clk_inh  <= 1'b1;
      ser      <= 1'b1;
      p        <= 8'h00;
      txd      <= 1'b1;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_q  <= ready_nxt;
      busy_q   <= busy_nxt;
      sh_ld_n  <= ld_nxt;
      clk_inh  <= inh_nxt;
      ser      <= 1'b1;
      p        <= p_nxt;
      txd      <= txd_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
    end
  end

  // Next-state and next-output decode; load/shift strobes default to inactive
  always_comb begin
    state_nxt = state;
    ready_nxt = ready_q;
    busy_nxt  = busy_q;
    ld_nxt    = 1'b1;
    inh_nxt   = 1'b1;
    p_nxt     = p;
    txd_nxt   = txd;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    case (state)
      IDLE: begin
        if (tx.tx_valid && ready_q) begin
          p_nxt     = bitrev8(tx.tx_data);
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          ld_nxt    = 1'b0;
          inh_nxt   = 1'b0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        txd_nxt   = 1'b0;
        state_nxt = START;
      end
      START: begin
        if (pre_last) begin
          inh_nxt = 1'b0;
        end
        if (baud_last) begin
          txd_nxt   = q;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        // Bit 7 is already on q; shifting again would only feed ser into the chain
        if (pre_last && (bit_cnt != 3'd7)) begin
          inh_nxt = 1'b0;
        end
        if (baud_last) begin
          if (bit_cnt == 3'd7) begin
            txd_nxt   = 1'b1;
            stop_nxt  = 1'b0;
            state_nxt = STOP;
          end else begin
            txd_nxt = q;
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// tb/tb_uart_tx_seq.sv - directed bench for uart_tx_seq with behavioural sn74ls166 shifters
module tb_uart_tx_seq;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       sel;
  logic       v;
  logic [7:0] d;

  always #5 clk = ~clk;

  uart_tx_seq_if if4 ();
  uart_tx_seq_if if3 ();

  assign if4.tx_valid = v & ~sel;
  assign if4.tx_data  = d;
  assign if3.tx_valid = v & sel;
  assign if3.tx_data  = d;

  logic       ld4, inh4, ser4, q4, txd4;
  logic       ld3, inh3, ser3, q3, txd3;
  logic [7:0] p4, p3;
  logic [7:0] sr4, sr3;

  uart_tx_seq #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
    .clk(clk), .clr_n(clr_n), .tx(if4), .sh_ld_n(ld4), .clk_inh(inh4),
    .ser(ser4), .p(p4), .q(q4), .txd(txd4)
  );

  uart_tx_seq #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut3 (
    .clk(clk), .clr_n(clr_n), .tx(if3), .sh_ld_n(ld3), .clk_inh(inh3),
    .ser(ser3), .p(p3), .q(q3), .txd(txd3)
  );

  // sn74ls166 models: load p, shift toward stage 7 with ser entering stage 0, or hold
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr4 <= 8'h00;
      sr3 <= 8'h00;
    end else begin
      if (!inh4) sr4 <= ld4 ? {sr4[6:0], ser4} : p4;
      if (!inh3) sr3 <= ld3 ? {sr3[6:0], ser3} : p3;
    end
  end
  assign q4 = sr4[7];
  assign q3 = sr3[7];

  wire       m_txd  = sel ? txd3 : txd4;
  wire       m_rdy  = sel ? if3.tx_ready : if4.tx_ready;
  wire       m_busy = sel ? if3.tx_busy : if4.tx_busy;
  wire       m_ld   = sel ? ld3 : ld4;
  wire       m_inh  = sel ? inh3 : inh4;
  wire       m_ser  = sel ? ser3 : ser4;
  wire [7:0] m_p    = sel ? p3 : p4;

  logic       tr_txd [0:127];
  logic       tr_rdy [0:127];
  logic       tr_busy[0:127];
  logic       tr_ld  [0:127];
  logic       tr_inh [0:127];
  logic [7:0] tr_p   [0:127];
  int         acc_at;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and wait (bounded) until the following edge will accept it
  task automatic accept(input logic [7:0] b);
    int w;
    d = b;
    v = 1'b1;
    w = 0;
    while (!m_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!m_rdy) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  // Record n negedge samples after the accept edge; optionally scramble data while busy
  task automatic capture(input int n, input bit junk, input logic [7:0] nxt, input int extra);
    int ex;
    ex = extra;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr_txd[i]  = m_txd;
      tr_rdy[i]  = m_rdy;
      tr_busy[i] = m_busy;
      tr_ld[i]   = m_ld;
      tr_inh[i]  = m_inh;
      tr_p[i]    = m_p;
      if (m_rdy) begin
        if (ex > 0) begin
          d = nxt;
          v = 1'b1;
          ex--;
          acc_at = i;
        end else begin
          v = 1'b0;
        end
      end else if (junk) begin
        d = 8'($urandom);
      end
    end
  endtask

  // Collect mid-bit samples of a 10-bit frame whose accept precedes offset base+1
  task automatic get_word(input int base, input int cpb, output logic [9:0] w);
    for (int j = 0; j < 10; j++) begin
      w[j] = tr_txd[base + 2 + j * cpb + cpb / 2];
    end
  endtask

  logic [9:0] word;
  int         cnt, nld, nsh, bad;

  initial begin
    clr_n  = 1'b0;
    sel    = 1'b0;
    v      = 1'b0;
    d      = 8'h00;
    acc_at = 0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // 1. reset state and idle line
    check_eq("rst_txd", 32'(m_txd), 32'd1);
    check_eq("rst_ready", 32'(m_rdy), 32'd1);
    check_eq("rst_busy", 32'(m_busy), 32'd0);
    check_eq("rst_ld_n", 32'(m_ld), 32'd1);
    check_eq("rst_inh", 32'(m_inh), 32'd1);
    check_eq("rst_ser", 32'(m_ser), 32'd1);
    check_eq("rst_p", 32'(m_p), 32'h00);
    capture(50, 1'b0, 8'h00, 0);
    cnt = 0;
    for (int i = 1; i <= 50; i++) if (tr_txd[i]) cnt++;
    check_eq("idle_txd_high", 32'(cnt), 32'd50);

    // 2. single byte 0x53
    accept(8'h53);
    capture(60, 1'b0, 8'h00, 0);
    check_eq("p_rev_53", 32'(tr_p[1]), 32'hCA);
    check_eq("txd_before_start", 32'(tr_txd[1]), 32'd1);
    check_eq("txd_start_fall", 32'(tr_txd[2]), 32'd0);
    check_eq("busy_in_frame", 32'(tr_busy[1]), 32'd1);
    get_word(0, 4, word);
    check_eq("frame_53", 32'(word), 32'h2A6);
    check_eq("ready_low_40", 32'(tr_rdy[41]), 32'd0);
    check_eq("ready_at_41", 32'(tr_rdy[42]), 32'd1);
    check_eq("busy_end", 32'(tr_busy[42]), 32'd0);

    // 3. load and shift pulse accounting for 0xA5
    accept(8'hA5);
    capture(50, 1'b0, 8'h00, 0);
    nld = 0; nsh = 0; bad = 0;
    for (int i = 1; i <= 50; i++) begin
      if (!tr_ld[i]) nld++;
      if (!tr_inh[i] && tr_ld[i]) begin
        nsh++;
        if (i < 5 || i > 33 || ((i - 1) % 4) != 0) bad++;
      end
    end
    check_eq("load_pulses", 32'(nld), 32'd1);
    check_eq("load_in_load_cycle", 32'(tr_ld[1]), 32'd0);
    check_eq("shift_pulses", 32'(nsh), 32'd8);
    check_eq("shift_misplaced", 32'(bad), 32'd0);
    get_word(0, 4, word);
    check_eq("frame_A5", 32'(word), 32'h34A);

    // 4. back-to-back 0x00 then 0xFF with junk on tx_data while busy
    accept(8'h00);
    capture(90, 1'b1, 8'hFF, 1);
    get_word(0, 4, word);
    check_eq("frame_00", 32'(word), 32'h200);
    check_eq("b2b_accept_at", 32'(acc_at), 32'd42);
    check_eq("b2b_load_gap_high", 32'(tr_txd[43]), 32'd1);
    check_eq("b2b_second_start", 32'(tr_txd[44]), 32'd0);
    get_word(42, 4, word);
    check_eq("frame_FF", 32'(word), 32'h3FE);
    check_eq("b2b_ready_low", 32'(tr_rdy[83]), 32'd0);
    check_eq("b2b_ready_high", 32'(tr_rdy[84]), 32'd1);

    // 5. reset during DATA bit 3 of 0x0F, then 0x3C
    accept(8'h0F);
    capture(19, 1'b0, 8'h00, 0);
    check_eq("mid_bit3", 32'(tr_txd[19]), 32'd1);
    v = 1'b0;
    clr_n = 1'b0;
    #1;
    check_eq("abort_txd", 32'(m_txd), 32'd1);
    check_eq("abort_ready", 32'(m_rdy), 32'd1);
    check_eq("abort_busy", 32'(m_busy), 32'd0);
    check_eq("abort_inh", 32'(m_inh), 32'd1);
    @(negedge clk);
    clr_n = 1'b1;
    capture(10, 1'b0, 8'h00, 0);
    cnt = 0;
    for (int i = 1; i <= 10; i++) if (tr_txd[i] && tr_rdy[i]) cnt++;
    check_eq("no_retransmit", 32'(cnt), 32'd10);
    accept(8'h3C);
    capture(50, 1'b0, 8'h00, 0);
    get_word(0, 4, word);
    check_eq("frame_3C", 32'(word), 32'h278);

    // 6. two stop bits, CLKS_PER_BIT=3, byte 0x81
    sel = 1'b1;
    @(negedge clk);
    accept(8'h81);
    capture(50, 1'b0, 8'h00, 0);
    check_eq("p_rev_81", 32'(tr_p[1]), 32'h81);
    get_word(0, 3, word);
    check_eq("frame_81", 32'(word), 32'h302);
    cnt = 0;
    for (int i = 29; i <= 34; i++) if (tr_txd[i]) cnt++;
    check_eq("stop2_high", 32'(cnt), 32'd6);
    check_eq("stop2_ready_low", 32'(tr_rdy[34]), 32'd0);
    check_eq("stop2_ready_at_34", 32'(tr_rdy[35]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
